// File: rtl/stopwatch_counter.sv
// BCD MM:SS stopwatch counter driven by resynchronised 1 Hz / 2 Hz divider clocks.
// Define STOPWATCH_SATURATE_EN to saturate at MAX_MIN:59 and pause instead of wrapping.
module stopwatch_counter #(
    parameter int SYNC_STAGES = 2,
    parameter int MAX_MIN     = 59
) (
    input  logic       masterClk,
    input  logic       rst,
    input  logic       incClk,
    input  logic       adjClk,
    input  logic       pause_p,
    input  logic       adj,
    input  logic       sel,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       running,
    output logic       adjusting,
    output logic       rollover
);

    localparam logic [3:0] MAX_TENS = 4'(MAX_MIN / 10);
    localparam logic [3:0] MAX_ONES = 4'(MAX_MIN % 10);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        PAUSED = 2'd1,
        ADJUST = 2'd2
    } state_t;

    state_t state;
    state_t savedState;

    logic [SYNC_STAGES-1:0] incSync;
    logic [SYNC_STAGES-1:0] adjSync;
    logic                   incHist;
    logic                   adjHist;
    logic                   incTick;
    logic                   adjTick;
    logic                   minAtMax;
    logic                   secAtMax;

    function automatic logic [7:0] nextMin(input logic [3:0] t, input logic [3:0] o);
        if (t == MAX_TENS && o == MAX_ONES) begin
            return 8'h00;
        end else if (o == 4'd9) begin
            return {t + 4'd1, 4'd0};
        end else begin
            return {t, o + 4'd1};
        end
    endfunction

    function automatic logic [7:0] nextSec(input logic [3:0] t, input logic [3:0] o);
        if (t == 4'd5 && o == 4'd9) begin
            return 8'h00;
        end else if (o == 4'd9) begin
            return {t + 4'd1, 4'd0};
        end else begin
            return {t, o + 4'd1};
        end
    endfunction

    // Resynchronise both divider clocks and keep one history flop for edge detection.
    always_ff @(posedge masterClk) begin
        if (rst) begin
            incSync <= '0;
            adjSync <= '0;
            incHist <= 1'b0;
            adjHist <= 1'b0;
        end else begin
            incSync <= {incSync[SYNC_STAGES-2:0], incClk};
            adjSync <= {adjSync[SYNC_STAGES-2:0], adjClk};
            incHist <= incSync[SYNC_STAGES-1];
            adjHist <= adjSync[SYNC_STAGES-1];
        end
    end

    assign incTick  = incSync[SYNC_STAGES-1] & ~incHist;
    assign adjTick  = adjSync[SYNC_STAGES-1] & ~adjHist;
    assign minAtMax = (min_tens == MAX_TENS) && (min_ones == MAX_ONES);
    assign secAtMax = (sec_tens == 4'd5) && (sec_ones == 4'd9);

    // Mode FSM with the BCD digit registers; mode flags are registered alongside state.
    always_ff @(posedge masterClk) begin
        if (rst) begin
            state      <= RUN;
            savedState <= RUN;
            running    <= 1'b1;
            adjusting  <= 1'b0;
            rollover   <= 1'b0;
            min_tens   <= 4'd0;
            min_ones   <= 4'd0;
            sec_tens   <= 4'd0;
            sec_ones   <= 4'd0;
        end else begin
            rollover <= 1'b0;
            case (state)
                RUN, PAUSED: begin
                    // adj wins over a same-cycle pause_p, which is simply dropped
                    if (adj) begin
                        savedState <= state;
                        state      <= ADJUST;
                        running    <= 1'b0;
                        adjusting  <= 1'b1;
                    end else if (pause_p) begin
                        state   <= (state == RUN) ? PAUSED : RUN;
                        running <= (state == PAUSED);
                    end else if (state == RUN && incTick) begin
                        if (minAtMax && secAtMax) begin
                            rollover <= 1'b1;
`ifdef STOPWATCH_SATURATE_EN
                            state    <= PAUSED;
                            running  <= 1'b0;
`else
                            min_tens <= 4'd0;
                            min_ones <= 4'd0;
                            sec_tens <= 4'd0;
                            sec_ones <= 4'd0;
`endif
                        end else if (secAtMax) begin
                            sec_tens               <= 4'd0;
                            sec_ones               <= 4'd0;
                            {min_tens, min_ones}   <= nextMin(min_tens, min_ones);
                        end else begin
                            {sec_tens, sec_ones}   <= nextSec(sec_tens, sec_ones);
                        end
                    end else begin
                        state <= state;
                    end
                end
                ADJUST: begin
                    if (!adj) begin
                        state     <= savedState;
                        running   <= (savedState == RUN);
                        adjusting <= 1'b0;
                    end else if (adjTick) begin
                        if (sel) begin
                            {sec_tens, sec_ones} <= nextSec(sec_tens, sec_ones);
                        end else begin
                            {min_tens, min_ones} <= nextMin(min_tens, min_ones);
                        end
                    end else begin
                        state <= state;
                    end
                end
                default: begin
                    state     <= RUN;
                    running   <= 1'b1;
                    adjusting <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stopwatch_counter.sv
// Self-checking bench: directed scenarios plus random stimulus against a seconds-based reference model.
module tb_stopwatch_counter;

    localparam int SYNC = 2;
    localparam int MAXM = 59;

    logic       masterClk = 1'b0;
    logic       rst = 1'b1;
    logic       incClk = 1'b0;
    logic       adjClk = 1'b0;
    logic       pause_p = 1'b0;
    logic       adj = 1'b0;
    logic       sel = 1'b0;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       running, adjusting, rollover;

    int nChecks = 0;
    int nFail = 0;
    bit chkEn = 1'b0;

    // reference model state: plain minutes/seconds integers and a mode number
    int mm = 0, ss = 0, mode = 0, saved = 0;
    bit mRoll = 1'b0;
    bit incV [0:5];
    bit adjV [0:5];

    stopwatch_counter #(.SYNC_STAGES(SYNC), .MAX_MIN(MAXM)) dut (
        .masterClk(masterClk), .rst(rst), .incClk(incClk), .adjClk(adjClk),
        .pause_p(pause_p), .adj(adj), .sel(sel),
        .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
        .running(running), .adjusting(adjusting), .rollover(rollover)
    );

    always #5 masterClk = ~masterClk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // mode: 0 = RUN, 1 = PAUSED, 2 = ADJUST; input samples are a delay line in masterClk edges
    task automatic modelStep();
        bit iT, aT;
        if (rst) begin
            mm = 0; ss = 0; mode = 0; saved = 0; mRoll = 1'b0;
            for (int i = 0; i < 6; i++) begin
                incV[i] = 1'b0;
                adjV[i] = 1'b0;
            end
        end else begin
            iT = incV[SYNC-1] && !incV[SYNC];
            aT = adjV[SYNC-1] && !adjV[SYNC];
            for (int i = 5; i > 0; i--) begin
                incV[i] = incV[i-1];
                adjV[i] = adjV[i-1];
            end
            incV[0] = incClk;
            adjV[0] = adjClk;
            mRoll = 1'b0;
            if (mode != 2) begin
                if (adj) begin
                    saved = mode;
                    mode = 2;
                end else if (pause_p) begin
                    mode = 1 - mode;
                end else if (mode == 0 && iT) begin
                    if (mm == MAXM && ss == 59) begin
                        mRoll = 1'b1;
`ifdef STOPWATCH_SATURATE_EN
                        mode = 1;
`else
                        mm = 0;
                        ss = 0;
`endif
                    end else begin
                        mm = (mm * 60 + ss + 1) / 60;
                        ss = (ss + 1) % 60;
                    end
                end
            end else begin
                if (!adj) mode = saved;
                else if (aT && sel) ss = (ss + 1) % 60;
                else if (aT) mm = (mm + 1) % (MAXM + 1);
            end
        end
    endtask

    always @(posedge masterClk) modelStep();

    // every-cycle comparison of the DUT against the model
    always @(negedge masterClk) begin
        if (chkEn) begin
            check("min_tens", 8'(min_tens), 8'(mm / 10));
            check("min_ones", 8'(min_ones), 8'(mm % 10));
            check("sec_tens", 8'(sec_tens), 8'(ss / 10));
            check("sec_ones", 8'(sec_ones), 8'(ss % 10));
            check("running", 8'(running), 8'(mode == 0));
            check("adjusting", 8'(adjusting), 8'(mode == 2));
            check("rollover", 8'(rollover), 8'(mRoll));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge masterClk);
    endtask

    task automatic incPulse();
        incClk = 1'b1; cyc(5);
        incClk = 1'b0; cyc(5);
    endtask

    task automatic adjPulses(input int n);
        for (int i = 0; i < n; i++) begin
            adjClk = 1'b1; cyc(5);
            adjClk = 1'b0; cyc(5);
        end
    endtask

    task automatic pausePulse();
        pause_p = 1'b1; cyc(1);
        pause_p = 1'b0; cyc(1);
    endtask

    task automatic checkTime(input string name, input int m, input int s);
        check({name, "_mm"}, 8'(min_tens * 10 + min_ones), 8'(m));
        check({name, "_ss"}, 8'(sec_tens * 10 + sec_ones), 8'(s));
    endtask

    initial begin
        int rollCnt;
        cyc(2);
        chkEn = 1'b1;
        checkTime("reset", 0, 0);
        check("reset_running", 8'(running), 8'd1);
        check("reset_rollover", 8'(rollover), 8'd0);
        rst = 1'b0;
        cyc(2);

        // latency: update appears on the third edge after the first high sample
        incClk = 1'b1;
        cyc(1); check("lat_edge1", 8'(sec_ones), 8'd0);
        cyc(1); check("lat_edge2", 8'(sec_ones), 8'd0);
        cyc(1); check("lat_edge3", 8'(sec_ones), 8'd1);
        cyc(2); incClk = 1'b0; cyc(5);
        incPulse(); incPulse();
        checkTime("count3", 0, 3);
        check("count3_running", 8'(running), 8'd1);

        // preload 00:59 then carry into minutes
        adj = 1'b1; sel = 1'b1; cyc(1);
        adjPulses(56);
        adj = 1'b0; cyc(1);
        incPulse();
        checkTime("carry", 1, 0);

        // preload 59:59 then wrap
        adj = 1'b1; sel = 1'b0; cyc(1);
        adjPulses(58);
        sel = 1'b1;
        adjPulses(59);
        adj = 1'b0; cyc(1);
        checkTime("preload", 59, 59);
        rollCnt = 0;
        incClk = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i == 5) incClk = 1'b0;
            cyc(1);
            if (rollover === 1'b1) rollCnt++;
        end
        check("roll_pulses", 8'(rollCnt), 8'd1);
`ifdef STOPWATCH_SATURATE_EN
        checkTime("sat", 59, 59);
        check("sat_running", 8'(running), 8'd0);
        pausePulse();
`else
        checkTime("wrap", 0, 0);
        check("wrap_running", 8'(running), 8'd1);
`endif

        // pause holds digits
        pausePulse();
        repeat (5) incPulse();
        check("paused_running", 8'(running), 8'd0);
`ifdef STOPWATCH_SATURATE_EN
        checkTime("paused", 59, 59);
`else
        checkTime("paused", 0, 0);
`endif
        pausePulse();
        incPulse(); incPulse();
`ifdef STOPWATCH_SATURATE_EN
        checkTime("resumed", 59, 59);
        check("resumed_running", 8'(running), 8'd0);
        pausePulse();
`else
        checkTime("resumed", 0, 2);
        check("resumed_running", 8'(running), 8'd1);
`endif

        // same-cycle adj and pause_p in RUN: adjust wins, pause dropped
        pause_p = 1'b1; adj = 1'b1; cyc(1);
        pause_p = 1'b0;
        check("adjpause_adjusting", 8'(adjusting), 8'd1);
        cyc(2);
        adj = 1'b0; cyc(1);
        check("adjpause_running", 8'(running), 8'd1);

        // reset coincident with an inc tick
        incClk = 1'b1; cyc(2);
        rst = 1'b1; incClk = 1'b0; cyc(1);
        rst = 1'b0;
        checkTime("rst_tick", 0, 0);
        check("rst_tick_running", 8'(running), 8'd1);
        check("rst_tick_rollover", 8'(rollover), 8'd0);
        cyc(3);

        // randomized phase
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 3) == 0) incClk = ~incClk;
            if ($urandom_range(0, 2) == 0) adjClk = ~adjClk;
            pause_p = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 59) == 0) adj = ~adj;
            sel = 1'($urandom_range(0, 1));
            rst = ($urandom_range(0, 1499) == 0);
            if (rst) begin
                incClk = 1'b0;
                adjClk = 1'b0;
            end
            cyc(1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFail);
        $finish;
    end

endmodule

// File: doc/stopwatch_counter.md
Name: stopwatch_counter

Overview:
- Consumer end of the stopwatch clock divider.
- Takes the divided square waves incClk (1 Hz) and adjClk (2 Hz), resynchronises them into the masterClk domain, and detects their rising edges.
- Uses those edges to drive a BCD MM:SS counter with run, pause and adjust modes.
- Digits feed the display multiplexer; mode outputs feed the blink logic.

Parameters:
- SYNC_STAGES, 2: flip-flop depth of each input synchroniser. Legal values 2..4.
- MAX_MIN, 59: highest minutes value. Legal values 1..99; minutes wrap from MAX_MIN to 0.

Ports:
- masterClk  in  1  100 MHz system clock; all logic on rising edge.
- rst  in  1  Reset; synchronous, active-high.
- incClk  in  1  Count clock from the divider; each rising edge = one second.
- adjClk  in  1  Adjust clock from the divider; each rising edge = one adjust step.
- pause_p  in  1  Debounced single-cycle pulse; toggles run/pause.
- adj  in  1  Level; 1 = adjust mode.
- sel  in  1  Adjust target; 0 = minutes, 1 = seconds.
- min_tens  out  4  BCD minutes tens digit.
- min_ones  out  4  BCD minutes ones digit.
- sec_tens  out  4  BCD seconds tens digit, range 0..5.
- sec_ones  out  4  BCD seconds ones digit.
- running  out  1  1 when state is RUN.
- adjusting  out  1  1 when state is ADJUST.
- rollover  out  1  One-cycle pulse on wrap from MAX_MIN:59 to 00:00.

Behaviour:
- Reset (rst=1 at a masterClk edge):
  - all digits 0; running=1; adjusting=0; rollover=0;
  - state RUN; saved_state RUN;
  - all synchroniser and edge-history flops cleared to 0.
- Synchronisers: incClk and adjClk each pass through SYNC_STAGES flops, then one history flop.
  - inc_tick = sync_out & ~hist; adj_tick is formed the same way.
  - Each tick is one masterClk cycle wide.
- Latency: a digit update is visible SYNC_STAGES+1 masterClk edges after the first edge that samples the input high (3 edges at default).
- The divider shares rst and releases low, so no spurious tick occurs at reset release.
- States: RUN, PAUSED, ADJUST.
  - RUN: pause_p goes to PAUSED. inc_tick increments seconds.
  - PAUSED: pause_p goes to RUN. Ticks are ignored; digits hold.
  - RUN or PAUSED with adj=1: save current state to saved_state, go to ADJUST.
  - ADJUST with adj=0: return to saved_state.
  - ADJUST: pause_p is ignored; inc_tick is ignored.
  - adj has priority over pause_p in the same cycle; that pause_p is dropped, not queued.
- RUN increment on inc_tick:
  - sec_ones 9 -> 0 with carry to sec_tens.
  - sec_tens 5 with sec_ones 9 -> seconds 00 and carry to minutes.
  - Minutes count in BCD and wrap MAX_MIN -> 00.
  - At MAX_MIN:59, the next tick gives 00:00 and rollover=1 for exactly that cycle.
- ADJUST increment on adj_tick:
  - sel=0: minutes +1, wrapping MAX_MIN -> 00.
  - sel=1: seconds +1, wrapping 59 -> 00.
  - No carry between fields; rollover is never asserted.
  - sel is sampled in the tick cycle.
- Mode outputs: running = (state==RUN); adjusting = (state==ADJUST). Both are registered with the state.
- Digits are registered. Digit values 10..15 and sec_tens above 5 are unreachable.
- Reset mid-operation wins over every tick and pulse in the same cycle.

Optional Feature:
- Macro: STOPWATCH_SATURATE_EN.
- Defined:
  - at MAX_MIN:59 an inc_tick leaves the digits at MAX_MIN:59 and forces state PAUSED (running=0);
  - rollover pulses once on that tick; later ticks produce nothing until pause_p resumes;
  - resuming at MAX_MIN:59 saturates again on the next tick;
  - ADJUST wrap behaviour is unchanged.
- Undefined: RUN wraps to 00:00 as described in Behaviour.

Test Plan:
- Reset, then toggle incClk with a 10-cycle period, 3 rising edges -> digits 00:03; each update 3 masterClk edges after the sampled rise; running=1.
- Preload 00:59 via adjust, then return to RUN, then one inc edge -> 01:00, rollover stays 0. Preload 59:59, then one inc edge -> 00:00, rollover=1 for exactly 1 cycle. With STOPWATCH_SATURATE_EN: stays 59:59, running=0, rollover pulses once.
- pause_p in RUN, then 5 inc edges -> digits unchanged, running=0. Second pause_p, then 2 inc edges -> count +2, running=1.
- adj=1, sel=1 from 00:58 with 3 adjClk edges -> 00:01, minutes untouched. sel=0 from 59:xx with 1 edge -> 00:xx, rollover=0. adj=0 -> returns to the pre-adjust state.
- pause_p and adj rise in the same cycle while in RUN -> ADJUST entered, saved_state=RUN; after adj=0, running=1.
- rst asserted in the same cycle as inc_tick at 12:34 -> next cycle all digits 0, state RUN, no rollover.
